// File: rtl/uart_pkg.sv
// Shared UART types used by the receiver, the transmitter and the receive-side buffer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream bundle around the receive buffer: receiver strobe in, consumer handshake out.
// Latency: none (wires only).
// Backpressure: in_valid cannot be stalled; the out side is valid/ready.
// Ports: in_valid/in_data (receiver strobe and byte), out_valid/out_data/out_ready (consumer).
//   slave  = view of the buffer itself, master = view of whoever drives it.
interface uart_rx_fifo_if;
  import uart_pkg::*;

  logic       in_valid;
  uart_byte_t in_data;
  logic       out_valid;
  uart_byte_t out_data;
  logic       out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

endinterface

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Generic synchronous first-word-fall-through byte FIFO with wrap-bit pointers.
// Latency: a byte pushed at edge N is visible on head_data from cycle N+1.
// Backpressure: none internally; the caller must only push when !full (or popping) and pop when !empty.
// Ports: clk, rst (sync, active-high), push/push_data, pop, head_data, count, full, empty.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  uart_byte_t             push_data,
  input  logic                   pop,
  output uart_byte_t             head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  uart_byte_t     mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate occupancy register; they roll over modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is deliberately not reset; stale entries are never visible
  // because the head is only meaningful while !empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr[AW-1:0]];

  // Modular difference of the wrap-bit pointers is the occupancy 0..DEPTH.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver; drops bytes when full and counts them.
// Latency: one cycle from the in_valid strobe to out_valid/out_data.
// Backpressure: out side is valid/ready; the receiver cannot be stalled, so overflow bytes are dropped.
// Ports: clk, rst (sync, active-high), bus (uart_rx_fifo_if.slave), count, full, empty,
//   overflow (sticky drop flag), drop_cnt (saturating drop count), overflow_clr (clears both).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt,
  input  logic                   overflow_clr
);

  logic pop;
  logic push;
  logic drop;

  assign bus.out_valid = !empty;
  assign pop           = bus.out_valid && bus.out_ready;

  // A full FIFO still accepts a byte when the head leaves in the same cycle,
  // which keeps sustained throughput at one byte per cycle.
  assign push = bus.in_valid && (!full || pop);
  assign drop = bus.in_valid && full && !pop;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (pop),
    .head_data (bus.out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // A drop coinciding with a clear wins, so the dropped byte is never lost
  // from the statistics: the counter restarts at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clr)
        drop_cnt <= DROP_W'(1);
      else if (drop_cnt != '1)
        drop_cnt <= drop_cnt + DROP_W'(1);
    end else if (overflow_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes queued at stimulus, checked on every pop.
// Latency: checks out_valid one cycle after each push.
// Backpressure: drives out_ready directly (held low, high, and random).
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic              overflow_clr;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  uart_byte_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Monitor: every cycle a pop is about to happen, the head must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pop: got 0x%0h, required no output", bus.out_data);
      end else begin
        check("out_data", {24'h0, bus.out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One-cycle receiver strobe; expect says whether the byte should be stored.
  task automatic strobe(input uart_byte_t b, input bit expect_store);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    if (expect_store) exp_q.push_back(b);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    check("drain_done", {31'h0, ok}, 32'h1);
    sample();
    check("empty_after_drain", {31'h0, empty}, 32'h1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    overflow_clr  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    sample();
    check("rst_count",     {27'h0, count},     32'h0);
    check("rst_empty",     {31'h0, empty},     32'h1);
    check("rst_full",      {31'h0, full},      32'h0);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_overflow",  {31'h0, overflow},  32'h0);
    check("rst_drop_cnt",  {30'h0, drop_cnt},  32'h0);

    // Basic pass-through: each byte visible one cycle after its push, popped immediately
    bus.out_ready = 1'b1;
    strobe(8'h55, 1'b1);
    sample();
    check("pt1_valid", {31'h0, bus.out_valid}, 32'h1);
    check("pt1_data",  {24'h0, bus.out_data},  32'h55);
    tick();
    sample();
    check("pt1_count", {27'h0, count}, 32'h0);
    check("pt1_valid_off", {31'h0, bus.out_valid}, 32'h0);
    repeat (432) tick();
    strobe(8'hA3, 1'b1);
    sample();
    check("pt2_valid", {31'h0, bus.out_valid}, 32'h1);
    check("pt2_data",  {24'h0, bus.out_data},  32'hA3);
    tick();
    sample();
    check("pt2_count", {27'h0, count}, 32'h0);
    bus.out_ready = 1'b0;

    // Fill to full
    for (int i = 0; i < DEPTH; i++) strobe(8'(i), 1'b1);
    sample();
    check("fill_full",  {31'h0, full},  32'h1);
    check("fill_count", {27'h0, count}, 32'd16);

    // Overflow while full: three drops, contents untouched
    repeat (3) strobe(8'hEE, 1'b0);
    sample();
    check("ovf_flag",  {31'h0, overflow}, 32'h1);
    check("ovf_drops", {30'h0, drop_cnt}, 32'h3);
    check("ovf_count", {27'h0, count},    32'd16);

    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    sample();
    check("clr_flag",  {31'h0, overflow}, 32'h0);
    check("clr_drops", {30'h0, drop_cnt}, 32'h0);

    // Push and pop in the same cycle while full: accepted, no drop
    bus.out_ready = 1'b1;
    strobe(8'h77, 1'b1);
    bus.out_ready = 1'b0;
    sample();
    check("pp_count", {27'h0, count},    32'd16);
    check("pp_flag",  {31'h0, overflow}, 32'h0);
    check("pp_drops", {30'h0, drop_cnt}, 32'h0);
    drain();

    // Saturation and clear
    for (int i = 0; i < DEPTH; i++) strobe(8'(8'h20 + i), 1'b1);
    repeat (2) strobe(8'hEE, 1'b0);
    sample();
    check("sat_two", {30'h0, drop_cnt}, 32'h2);
    repeat (3) strobe(8'hEE, 1'b0);
    sample();
    check("sat_five", {30'h0, drop_cnt}, 32'h3);
    overflow_clr = 1'b1;
    strobe(8'hEE, 1'b0);
    overflow_clr = 1'b0;
    sample();
    check("clr_drop_cnt",  {30'h0, drop_cnt}, 32'h1);
    check("clr_drop_flag", {31'h0, overflow}, 32'h1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    sample();
    check("clr_only_cnt",  {30'h0, drop_cnt}, 32'h0);
    check("clr_only_flag", {31'h0, overflow}, 32'h0);
    drain();

    // 40 bytes with random out_ready, crossing pointer wrap
    for (int k = 0; k < 80; k++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (k % 2 == 0) begin
        uart_byte_t b;
        b = 8'(8'h80 + k / 2);
        strobe(b, (exp_q.size() < DEPTH) || bus.out_ready);
      end else begin
        tick();
      end
    end
    drain();

    // Reset with 5 bytes stored and overflow set
    for (int i = 0; i < DEPTH; i++) strobe(8'(8'hC0 + i), 1'b1);
    strobe(8'hEE, 1'b0);
    bus.out_ready = 1'b1;
    repeat (11) tick();
    bus.out_ready = 1'b0;
    sample();
    check("pre_rst_count", {27'h0, count},    32'd5);
    check("pre_rst_flag",  {31'h0, overflow}, 32'h1);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    sample();
    check("mrst_count", {27'h0, count},         32'h0);
    check("mrst_valid", {31'h0, bus.out_valid}, 32'h0);
    check("mrst_flag",  {31'h0, overflow},      32'h0);
    check("mrst_drops", {30'h0, drop_cnt},      32'h0);

    // Normal operation resumes after reset
    bus.out_ready = 1'b1;
    strobe(8'h5A, 1'b1);
    sample();
    check("post_rst_valid", {31'h0, bus.out_valid}, 32'h1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
